seven_seg_scan_driver: RTL and testbench
========================================

# seven_seg_scan_driver

Time-multiplexed, parametrised seven-segment display driver. It generalises the single-digit switch-to-glyph decoder to N digits with a scanned common anode, an inter-digit blanking gap and a glyph set covering hex and status letters. Digit codes are double-buffered, so a display update never tears mid-frame. It sits between the control FSM that produces status codes and the board's segment and anode pins.

## Interface
- N_DIGITS, 4: digits scanned, 1..8.
- DWELL_CYCLES, 50000: clk cycles per digit slot, ≥2.
- BLANK_CYCLES, 500: cycles at the end of each slot with all anodes off, < DWELL_CYCLES.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low forces blank and holds counters.
- load  in  1  single-cycle strobe capturing digit_codes and dp_in into the staging register.
- digit_codes  in  5*N_DIGITS  glyph code; digit i occupies [5i+4:5i].
- dp_in  in  N_DIGITS  decimal point request per digit, 1 = on.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- an_n  out  N_DIGITS  digit anodes, active-low, at most one low.
- pending  out  1  staging data not yet committed to display.
- frame_done  out  1  one-cycle pulse at each frame wrap.

## Operation
- Reset values: seg_n=7'h7F, dp_n=1, an_n all 1, frame_done=0, pending=0. Internally: digit index=0, slot counter=0, staging and display registers hold code 5'h1F (blank) and dp=0.
- Slot counter runs 0..DWELL_CYCLES-1 while en=1. At DWELL_CYCLES-1 it wraps to 0 and the digit index advances. The index wraps N_DIGITS-1 → 0.
- While counter < DWELL_CYCLES-BLANK_CYCLES, an_n[index]=0 and seg_n/dp_n show display[index]. Otherwise all outputs are blank (an_n all 1, seg_n 7'h7F, dp_n 1).
- Glyph map (active-low g..a):
  - 0x00-0x0F hex: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110, and the standard rest.
  - 0x10 'I'=1001111, 0x11 'P'=0001100, 0x12 '-'=0111111.
  - All other codes are blank, 1111111.
- load: staging ← {digit_codes, dp_in}, pending ← 1. A later load before commit overwrites staging; the last one wins.
- Commit happens on the frame-wrap edge (counter=DWELL_CYCLES-1, index=N_DIGITS-1, en=1). On that edge, display ← staging, pending ← 0, and frame_done pulses.
- If load coincides with the commit edge, the new data goes to staging, the old staging is committed, and pending stays 1.
- en=0: counter and index hold, outputs are blank, load still captures, and no commit occurs. When en returns high, scanning resumes from the held state.
- Reset asserted mid-frame returns every register to its reset value immediately.

## Timing
- All outputs are registered. seg_n/an_n/dp_n reflect the (index, counter) state of the previous cycle, so latency is 1 cycle.
- frame_done is high for exactly the one cycle after the commit edge.
- pending rises the cycle after load and falls the cycle after commit.
- Frame period is N_DIGITS*DWELL_CYCLES cycles. Each digit is lit for DWELL_CYCLES-BLANK_CYCLES cycles per frame.
- Worst-case load-to-display delay is N_DIGITS*DWELL_CYCLES+1 cycles.

## Structure
- Shared package holds glyph-code constants (GLYPH_I, GLYPH_P, GLYPH_DASH, GLYPH_BLANK), the code width 5, and the blank segment constant 7'h7F.
- One sub-module, glyph_decoder: a purely combinational 5-bit code → 7-bit active-low pattern.
- The top level holds the counters, staging/display registers and output registers.

## Test plan
- Reset: hold reset_n=0 with en=1. Expect an_n=all 1, seg_n=7'h7F, pending=0. Release reset; the first lit slot is an_n=4'b1110 showing blank.
- Scan (N=4, DWELL=8, BLANK=2): load codes {3,2,1,0}, wait one frame. Expect digit 0 seg_n=1000000 for 6 cycles, then blank for 2 cycles, then an_n=1101 with seg_n=1111001, wrapping after 32 cycles.
- Letters and dp: load {0x11,0x10,0x12,0x1F} with dp_in=4'b0001. Expect 'P'=0001100 on digit 3, 'I'=1001111 on digit 2, 0111111 on digit 1, 1111111 on digit 0 with dp_n=0.
- Tear-free update: pulse load mid-frame twice with different data. Expect the display unchanged until the wrap, then the second data shown, with frame_done and the pending fall both one cycle after the wrap edge.
- Coincident load and commit: load on the commit edge. Expect the previous staging displayed and pending=1 until the next wrap.
- Enable and reset: deassert en mid-slot. Expect blank outputs and the counter frozen for 20 cycles, then resumption at the same index. Assert reset_n mid-frame and expect immediate reset values.

Source files
------------

// File: rtl/seven_seg_scan_driver_pkg.sv
// rtl/seven_seg_scan_driver_pkg.sv - shared glyph codes and segment constants
package seven_seg_scan_driver_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] GLYPH_I     = 5'h10;
    localparam logic [CODE_W-1:0] GLYPH_P     = 5'h11;
    localparam logic [CODE_W-1:0] GLYPH_DASH  = 5'h12;
    localparam logic [CODE_W-1:0] GLYPH_BLANK = 5'h1F;

    // Segment order {g,f,e,d,c,b,a}, active-low: all ones means dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// rtl/seven_seg_scan_driver_if.sv - control-side and pin-side signals of the scan driver
interface seven_seg_scan_driver_if #(
    parameter int N_DIGITS = 4
);
    import seven_seg_scan_driver_pkg::*;

    logic                       en;
    logic                       load;
    logic [CODE_W*N_DIGITS-1:0] digit_codes;
    logic [N_DIGITS-1:0]        dp_in;
    logic [6:0]                 seg_n;
    logic                       dp_n;
    logic [N_DIGITS-1:0]        an_n;
    logic                       pending;
    logic                       frame_done;

    modport master (
        output en, load, digit_codes, dp_in,
        input  seg_n, dp_n, an_n, pending, frame_done
    );

    modport slave (
        input  en, load, digit_codes, dp_in,
        output seg_n, dp_n, an_n, pending, frame_done
    );

endinterface

// File: rtl/seven_seg_scan_driver_glyph_decoder.sv
// rtl/seven_seg_scan_driver_glyph_decoder.sv - 5-bit glyph code to active-low segment pattern
module seven_seg_scan_driver_glyph_decoder
    import seven_seg_scan_driver_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [6:0]        seg_n
);

    // Hex digits, three status letters, everything else dark.
    always_comb begin
        seg_n = SEG_BLANK;
        case (code)
            5'h00:      seg_n = 7'b1000000;
            5'h01:      seg_n = 7'b1111001;
            5'h02:      seg_n = 7'b0100100;
            5'h03:      seg_n = 7'b0110000;
            5'h04:      seg_n = 7'b0011001;
            5'h05:      seg_n = 7'b0010010;
            5'h06:      seg_n = 7'b0000010;
            5'h07:      seg_n = 7'b1111000;
            5'h08:      seg_n = 7'b0000000;
            5'h09:      seg_n = 7'b0010000;
            5'h0A:      seg_n = 7'b0001000;
            5'h0B:      seg_n = 7'b0000011;
            5'h0C:      seg_n = 7'b1000110;
            5'h0D:      seg_n = 7'b0100001;
            5'h0E:      seg_n = 7'b0000110;
            5'h0F:      seg_n = 7'b0001110;
            GLYPH_I:    seg_n = 7'b1001111;
            GLYPH_P:    seg_n = 7'b0001100;
            GLYPH_DASH: seg_n = 7'b0111111;
            default:    seg_n = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - time-multiplexed N-digit display driver with double-buffered codes
module seven_seg_scan_driver
    import seven_seg_scan_driver_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                       clk,
    input  logic                       reset_n,
    seven_seg_scan_driver_if.slave     bus
);

    localparam int CNT_W = $clog2(DWELL_CYCLES);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BUF_W = CODE_W * N_DIGITS;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [BUF_W-1:0]    stage_codes;
    logic [N_DIGITS-1:0] stage_dp;
    logic [BUF_W-1:0]    disp_codes;
    logic [N_DIGITS-1:0] disp_dp;

    logic                slot_end;
    logic                frame_wrap;
    logic                lit;
    logic [CODE_W-1:0]   cur_code;
    logic [6:0]          cur_seg_n;

    // Slot/frame boundaries and the visible part of each slot.
    always_comb begin
        slot_end   = (cnt == CNT_W'(DWELL_CYCLES - 1));
        frame_wrap = bus.en && slot_end && (idx == IDX_W'(N_DIGITS - 1));
        lit        = bus.en && (cnt < CNT_W'(DWELL_CYCLES - BLANK_CYCLES));
        cur_code   = disp_codes[CODE_W*idx +: CODE_W];
    end

    seven_seg_scan_driver_glyph_decoder u_decoder (
        .code  (cur_code),
        .seg_n (cur_seg_n)
    );

    // Scan position: slot counter and digit index, frozen while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (bus.en) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Double buffer: load fills staging, only the frame wrap moves it to display,
    // so a frame never shows a mix of old and new codes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_codes    <= {N_DIGITS{GLYPH_BLANK}};
            stage_dp       <= '0;
            disp_codes     <= {N_DIGITS{GLYPH_BLANK}};
            disp_dp        <= '0;
            bus.pending    <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.frame_done <= frame_wrap;
            if (frame_wrap) begin
                disp_codes <= stage_codes;
                disp_dp    <= stage_dp;
            end
            if (bus.load) begin
                stage_codes <= bus.digit_codes;
                stage_dp    <= bus.dp_in;
            end
            // A load on the wrap edge refills staging, so pending must stay set.
            if (bus.load)
                bus.pending <= 1'b1;
            else if (frame_wrap)
                bus.pending <= 1'b0;
        end
    end

    // Registered pin drive: one anode low during the lit part of a slot, else dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.an_n  <= '1;
            bus.seg_n <= SEG_BLANK;
            bus.dp_n  <= 1'b1;
        end else if (lit) begin
            bus.an_n  <= ~(N_DIGITS'(1) << idx);
            bus.seg_n <= cur_seg_n;
            bus.dp_n  <= ~disp_dp[idx];
        end else begin
            bus.an_n  <= '1;
            bus.seg_n <= SEG_BLANK;
            bus.dp_n  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - directed self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DWELL = 8;
    localparam int BLANK = 2;

    logic clk;
    logic reset_n;
    int   n_vec;
    int   n_bad;
    int   edge_n;

    seven_seg_scan_driver_if #(.N_DIGITS(N)) bus ();

    seven_seg_scan_driver #(
        .N_DIGITS     (N),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    // Leaves the bench at a negedge with the DUT at cnt=0, idx=0, edge_n=0.
    task automatic apply_reset();
        @(negedge clk);
        reset_n         = 1'b0;
        bus.en          = 1'b1;
        bus.load        = 1'b0;
        bus.digit_codes = '1;
        bus.dp_in       = '0;
        tick();
        tick();
        reset_n = 1'b1;
        edge_n  = 0;
    endtask

    task automatic do_load(input logic [19:0] codes, input logic [3:0] dp);
        bus.load        = 1'b1;
        bus.digit_codes = codes;
        bus.dp_in       = dp;
        tick();
        bus.load = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        bus.en   = 1'b1;
        bus.load = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (bus.an_n !== 4'b1111) begin n_bad++; $display("FAIL reset_an_n got %b want 1111", bus.an_n); end
        n_vec++; if (bus.seg_n !== 7'h7F) begin n_bad++; $display("FAIL reset_seg_n got %h want 7f", bus.seg_n); end
        n_vec++; if (bus.dp_n !== 1'b1) begin n_bad++; $display("FAIL reset_dp_n got %b want 1", bus.dp_n); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b want 0", bus.pending); end
        n_vec++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        reset_n = 1'b1;
        edge_n  = 0;
        tick();
        n_vec++; if (bus.an_n !== 4'b1110) begin n_bad++; $display("FAIL first_slot_an_n got %b want 1110", bus.an_n); end
        n_vec++; if (bus.seg_n !== 7'h7F) begin n_bad++; $display("FAIL first_slot_seg_n got %h want 7f", bus.seg_n); end
    endtask

    task automatic test_scan();
        apply_reset();
        do_load({5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000);
        n_vec++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL scan_pending_rise got %b want 1", bus.pending); end
        run_to(31);
        n_vec++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL scan_fd_early got %b want 0", bus.frame_done); end
        tick();
        n_vec++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL scan_fd got %b want 1", bus.frame_done); end
        n_vec++; if (bus.pending !== 1'b0) begin n_bad++; $display("FAIL scan_pending_fall got %b want 0", bus.pending); end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++; if (bus.an_n !== 4'b1110 || bus.seg_n !== 7'b1000000)
                begin n_bad++; $display("FAIL scan_d0_lit[%0d] got an=%b seg=%b want 1110/1000000", i, bus.an_n, bus.seg_n); end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++; if (bus.an_n !== 4'b1111 || bus.seg_n !== 7'h7F)
                begin n_bad++; $display("FAIL scan_d0_blank[%0d] got an=%b seg=%b want 1111/1111111", i, bus.an_n, bus.seg_n); end
        end
        tick();
        n_vec++; if (bus.an_n !== 4'b1101 || bus.seg_n !== 7'b1111001) begin n_bad++; $display("FAIL scan_d1 got an=%b seg=%b want 1101/1111001", bus.an_n, bus.seg_n); end
        run_to(49);
        n_vec++; if (bus.an_n !== 4'b1011 || bus.seg_n !== 7'b0100100) begin n_bad++; $display("FAIL scan_d2 got an=%b seg=%b want 1011/0100100", bus.an_n, bus.seg_n); end
        run_to(57);
        n_vec++; if (bus.an_n !== 4'b0111 || bus.seg_n !== 7'b0110000) begin n_bad++; $display("FAIL scan_d3 got an=%b seg=%b want 0111/0110000", bus.an_n, bus.seg_n); end
        run_to(64);
        n_vec++; if (bus.frame_done !== 1'b1) begin n_bad++; $display("FAIL scan_fd2 got %b want 1", bus.frame_done); end
        tick();
        n_vec++; if (bus.an_n !== 4'b1110 || bus.seg_n !== 7'b1000000) begin n_bad++; $display("FAIL scan_wrap got an=%b seg=%b want 1110/1000000", bus.an_n, bus.seg_n); end
        n_vec++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL scan_fd_width got %b want 0", bus.frame_done); end
    endtask

    task automatic test_letters_dp();
        apply_reset();
        do_load({5'h11, 5'h10, 5'h12, 5'h1F}, 4'b0001);
        run_to(33);
        n_vec++; if (bus.an_n !== 4'b1110 || bus.seg_n !== 7'b1111111 || bus.dp_n !== 1'b0)
            begin n_bad++; $display("FAIL let_d0 got an=%b seg=%b dp=%b want 1110/1111111/0", bus.an_n, bus.seg_n, bus.dp_n); end
        run_to(41);
        n_vec++; if (bus.an_n !== 4'b1101 || bus.seg_n !== 7'b0111111 || bus.dp_n !== 1'b1)
            begin n_bad++; $display("FAIL let_dash got an=%b seg=%b dp=%b want 1101/0111111/1", bus.an_n, bus.seg_n, bus.dp_n); end
        run_to(49);
        n_vec++; if (bus.an_n !== 4'b1011 || bus.seg_n !== 7'b1001111)
            begin n_bad++; $display("FAIL let_I got an=%b seg=%b want 1011/1001111", bus.an_n, bus.seg_n); end
        run_to(57);
        n_vec++; if (bus.an_n !== 4'b0111 || bus.seg_n !== 7'b0001100)
            begin n_bad++; $display("FAIL let_P got an=%b seg=%b want 0111/0001100", bus.an_n, bus.seg_n); end
        run_to(63);
        n_vec++; if (bus.dp_n !== 1'b1) begin n_bad++; $display("FAIL let_dp_blank got %b want 1", bus.dp_n); end
    endtask

    task automatic test_tear_free();
        apply_reset();
        do_load({5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000);
        run_to(40);
        do_load({5'h08, 5'h08, 5'h08, 5'h08}, 4'b0000);
        run_to(50);
        do_load({5'h0F, 5'h0F, 5'h0F, 5'h0F}, 4'b1111);
        run_to(57);
        n_vec++; if (bus.seg_n !== 7'b0110000 || bus.dp_n !== 1'b1)
            begin n_bad++; $display("FAIL tear_old_d3 got seg=%b dp=%b want 0110000/1", bus.seg_n, bus.dp_n); end
        run_to(63);
        n_vec++; if (bus.pending !== 1'b1 || bus.frame_done !== 1'b0)
            begin n_bad++; $display("FAIL tear_prewrap got pend=%b fd=%b want 1/0", bus.pending, bus.frame_done); end
        tick();
        n_vec++; if (bus.pending !== 1'b0 || bus.frame_done !== 1'b1)
            begin n_bad++; $display("FAIL tear_wrap got pend=%b fd=%b want 0/1", bus.pending, bus.frame_done); end
        tick();
        n_vec++; if (bus.an_n !== 4'b1110 || bus.seg_n !== 7'b0001110 || bus.dp_n !== 1'b0)
            begin n_bad++; $display("FAIL tear_new got an=%b seg=%b dp=%b want 1110/0001110/0", bus.an_n, bus.seg_n, bus.dp_n); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        do_load({5'h01, 5'h01, 5'h01, 5'h01}, 4'b0000);
        run_to(31);
        do_load({5'h02, 5'h02, 5'h02, 5'h02}, 4'b0000);
        n_vec++; if (bus.frame_done !== 1'b1 || bus.pending !== 1'b1)
            begin n_bad++; $display("FAIL coin_edge got fd=%b pend=%b want 1/1", bus.frame_done, bus.pending); end
        tick();
        n_vec++; if (bus.seg_n !== 7'b1111001) begin n_bad++; $display("FAIL coin_old got seg=%b want 1111001", bus.seg_n); end
        run_to(63);
        n_vec++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL coin_pend_hold got %b want 1", bus.pending); end
        tick();
        n_vec++; if (bus.pending !== 1'b0 || bus.frame_done !== 1'b1)
            begin n_bad++; $display("FAIL coin_wrap2 got pend=%b fd=%b want 0/1", bus.pending, bus.frame_done); end
        tick();
        n_vec++; if (bus.seg_n !== 7'b0100100) begin n_bad++; $display("FAIL coin_new got seg=%b want 0100100", bus.seg_n); end
    endtask

    task automatic test_enable_reset();
        apply_reset();
        do_load({5'h03, 5'h02, 5'h01, 5'h00}, 4'b0000);
        run_to(35);
        bus.en = 1'b0;
        do_load({5'h12, 5'h12, 5'h12, 5'h12}, 4'b0000);
        n_vec++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL en_load_capture got %b want 1", bus.pending); end
        for (int i = 0; i < 20; i++) begin
            n_vec++; if (bus.an_n !== 4'b1111 || bus.seg_n !== 7'h7F || bus.dp_n !== 1'b1)
                begin n_bad++; $display("FAIL en_blank[%0d] got an=%b seg=%b dp=%b want 1111/1111111/1", i, bus.an_n, bus.seg_n, bus.dp_n); end
            tick();
        end
        bus.en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (bus.an_n !== 4'b1110 || bus.seg_n !== 7'b1000000)
                begin n_bad++; $display("FAIL en_resume[%0d] got an=%b seg=%b want 1110/1000000", i, bus.an_n, bus.seg_n); end
        end
        tick();
        n_vec++; if (bus.an_n !== 4'b1111) begin n_bad++; $display("FAIL en_resume_gap got an=%b want 1111", bus.an_n); end
        tick();
        tick();
        n_vec++; if (bus.an_n !== 4'b1101 || bus.seg_n !== 7'b1111001)
            begin n_bad++; $display("FAIL en_next_digit got an=%b seg=%b want 1101/1111001", bus.an_n, bus.seg_n); end
        n_vec++; if (bus.pending !== 1'b1) begin n_bad++; $display("FAIL en_no_commit got %b want 1", bus.pending); end
        tick();
        reset_n = 1'b0;
        #1;
        n_vec++; if (bus.an_n !== 4'b1111 || bus.seg_n !== 7'h7F || bus.pending !== 1'b0 || bus.frame_done !== 1'b0)
            begin n_bad++; $display("FAIL async_reset got an=%b seg=%b pend=%b fd=%b want 1111/1111111/0/0", bus.an_n, bus.seg_n, bus.pending, bus.frame_done); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_vec++; if (bus.an_n !== 4'b1110 || bus.seg_n !== 7'h7F)
            begin n_bad++; $display("FAIL reset_display_cleared got an=%b seg=%b want 1110/1111111", bus.an_n, bus.seg_n); end
    endtask

    initial begin
        n_vec           = 0;
        n_bad           = 0;
        edge_n          = 0;
        reset_n         = 1'b0;
        bus.en          = 1'b1;
        bus.load        = 1'b0;
        bus.digit_codes = '1;
        bus.dp_in       = '0;
        test_reset();
        test_scan();
        test_letters_dp();
        test_tear_free();
        test_back_to_back();
        test_enable_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
